// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared types and widths for the sprite draw scheduler.
package sprite_draw_scheduler_pkg;

   localparam int X_W   = 8;
   localparam int Y_W   = 9;
   localparam int MIF_W = 8;
   localparam int CMD_W = X_W + Y_W + MIF_W;   // 25, packed {x, y, mif}

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2
   } seq_state_e;

endpackage

// File: rtl/sprite_draw_scheduler_fifo.sv
// Draw command FIFO: synchronous write, head visible combinationally, count output.
module draw_cmd_fifo
   import sprite_draw_scheduler_pkg::*;
#(
   parameter int WIDTH = CMD_W,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign do_push   = push && (count_q != CNT_FULL);
   assign do_pop    = pop && (count_q != '0);
   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Pointer wrap and occupancy update; push+pop together keeps the count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the count decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Round-robin arbiter feeding a command FIFO, drained by a draw sequencer.
//   state | meaning
//   IDLE  | waiting for a queued command and a ready drawer
//   ISSUE | draw strobe held until the drawer drops ready
//   BUSY  | drawer working; ready returning ends the sprite
module sprite_draw_scheduler
   import sprite_draw_scheduler_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       reqValid,
   input  logic [X_W*NUM_REQ-1:0]   reqX,
   input  logic [Y_W*NUM_REQ-1:0]   reqY,
   input  logic [MIF_W*NUM_REQ-1:0] reqMif,
   output logic [NUM_REQ-1:0]       reqAck,
   output logic [X_W-1:0]           drawX,
   output logic [Y_W-1:0]           drawY,
   output logic [MIF_W-1:0]         drawMif,
   output logic                     draw,
   input  logic                     drawerReady,
   output logic                     drawDone,
   output logic [2:0]               fifoCount
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

   logic [CMD_W-1:0] req_cmd [NUM_REQ];
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W:0]   cand_w;
   logic             grant_vld;
   logic [CMD_W-1:0] fifo_head;
   logic [2:0]       fifo_count;
   logic             fifo_pop;

   seq_state_e       state_q, state_d;
   logic             draw_q, draw_d;
   logic             done_q, done_d;
   logic [X_W-1:0]   x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic [MIF_W-1:0] mif_q, mif_d;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_cmd[g] = {reqX[g*X_W +: X_W], reqY[g*Y_W +: Y_W], reqMif[g*MIF_W +: MIF_W]};
   end

   // Round-robin search from rr_ptr; occupancy is the pre-pop value.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand_w    = '0;
      if (!reset && (fifo_count < DEPTH_C)) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand_w = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand_w >= (IDX_W+1)'(NUM_REQ)) cand_w = cand_w - (IDX_W+1)'(NUM_REQ);
            if (!grant_vld && reqValid[cand_w[IDX_W-1:0]]) begin
               grant_vld = 1'b1;
               grant_idx = cand_w[IDX_W-1:0];
            end
         end
      end
      rr_ptr_d = rr_ptr_q;
      if (grant_vld) rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
   end

   assign reqAck = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;

   draw_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (3)
   ) u_fifo (
      .clk       (clock),
      .rst       (reset),
      .push      (grant_vld),
      .push_data (req_cmd[grant_idx]),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   // Sequencer next-state: issue from the FIFO head, hand-shake on drawerReady.
   always_comb begin
      state_d  = state_q;
      draw_d   = draw_q;
      done_d   = 1'b0;
      x_d      = x_q;
      y_d      = y_q;
      mif_d    = mif_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if ((fifo_count != 3'd0) && drawerReady) begin
               {x_d, y_d, mif_d} = fifo_head;
               draw_d   = 1'b1;
               fifo_pop = 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (!drawerReady) begin
               draw_d  = 1'b0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (drawerReady) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            draw_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer, pointer and registered drawer outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         draw_q   <= 1'b0;
         done_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         mif_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         draw_q   <= draw_d;
         done_q   <= done_d;
         x_q      <= x_d;
         y_q      <= y_d;
         mif_q    <= mif_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign draw      = draw_q;
   assign drawDone  = done_q;
   assign drawX     = x_q;
   assign drawY     = y_q;
   assign drawMif   = mif_q;
   assign fifoCount = fifo_count;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Randomised and directed bench for sprite_draw_scheduler against a queue-based model.
module tb_sprite_draw_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  reqValid;
   logic [31:0] reqX;
   logic [35:0] reqY;
   logic [31:0] reqMif;
   logic [3:0]  reqAck;
   logic [7:0]  drawX;
   logic [8:0]  drawY;
   logic [7:0]  drawMif;
   logic        draw;
   logic        drawerReady;
   logic        drawDone;
   logic [2:0]  fifoCount;

   sprite_draw_scheduler #(.NUM_REQ(4), .FIFO_DEPTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .reqValid    (reqValid),
      .reqX        (reqX),
      .reqY        (reqY),
      .reqMif      (reqMif),
      .reqAck      (reqAck),
      .drawX       (drawX),
      .drawY       (drawY),
      .drawMif     (drawMif),
      .draw        (draw),
      .drawerReady (drawerReady),
      .drawDone    (drawDone),
      .fifoCount   (fifoCount)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // stimulus state
   logic [3:0] sv;
   logic [7:0] sx [4];
   logic [8:0] sy [4];
   logic [7:0] sm [4];
   logic       rdy;

   // behavioural model: a command queue plus the drawer hand-shake phase
   // (0 = waiting, 1 = strobing, 2 = drawer working)
   logic [24:0] cmd_q [$];
   int          rr;
   int          phase;
   logic        m_draw, m_done;
   logic [7:0]  m_x;
   logic [8:0]  m_y;
   logic [7:0]  m_mif;
   int          last_grant;
   logic [3:0]  last_ack_dut;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      cmd_q.delete();
      rr = 0; phase = 0;
      m_draw = 0; m_done = 0; m_x = 0; m_y = 0; m_mif = 0;
      last_grant = -1;
   endtask

   function automatic int model_grant();
      if (cmd_q.size() >= 4) return -1;
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (rr + k) % 4;
         if (sv[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_edge(input int g);
      logic [24:0] h;
      m_done = 0;
      if (phase == 0) begin
         if (cmd_q.size() > 0 && rdy) begin
            h = cmd_q.pop_front();
            m_x = h[24:17]; m_y = h[16:8]; m_mif = h[7:0];
            m_draw = 1; phase = 1;
         end
      end else if (phase == 1) begin
         if (!rdy) begin m_draw = 0; phase = 2; end
      end else begin
         if (rdy) begin m_done = 1; phase = 0; end
      end
      if (g >= 0) begin
         cmd_q.push_back({sx[g], sy[g], sm[g]});
         rr = (g + 1) % 4;
      end
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < 4; i++) begin
         reqX[i*8 +: 8]   = sx[i];
         reqY[i*9 +: 9]   = sy[i];
         reqMif[i*8 +: 8] = sm[i];
      end
      reqValid    = sv;
      drawerReady = rdy;
   endtask

   // One clock: check combinational ack before the edge, registered outputs after it.
   task automatic step();
      int g;
      logic [3:0] exp_ack;
      apply_inputs();
      #1;
      g = model_grant();
      exp_ack = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      last_ack_dut = reqAck;
      chk("reqAck", {28'd0, reqAck}, {28'd0, exp_ack});
      @(posedge clock);
      model_edge(g);
      last_grant = g;
      @(negedge clock);
      chk("draw", {31'd0, draw}, {31'd0, m_draw});
      chk("drawX", {24'd0, drawX}, {24'd0, m_x});
      chk("drawY", {23'd0, drawY}, {23'd0, m_y});
      chk("drawMif", {24'd0, drawMif}, {24'd0, m_mif});
      chk("drawDone", {31'd0, drawDone}, {31'd0, m_done});
      chk("fifoCount", {29'd0, fifoCount}, cmd_q.size());
   endtask

   // Asserts reset between edges so an asynchronous drop is observable at once.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      chk("rst_draw", {31'd0, draw}, 0);
      chk("rst_count", {29'd0, fifoCount}, 0);
      chk("rst_ack", {28'd0, reqAck}, 0);
      chk("rst_done", {31'd0, drawDone}, 0);
      chk("rst_drawX", {24'd0, drawX}, 0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic new_req(input int i);
      sv[i] = 1'b1;
      sx[i] = 8'($urandom);
      sy[i] = 9'($urandom);
      sm[i] = 8'($urandom);
   endtask

   task automatic rand_req_update();
      for (int i = 0; i < 4; i++) begin
         if (i == last_grant) begin
            if ($urandom_range(1) == 1) new_req(i);
            else sv[i] = 1'b0;
         end else if (!sv[i] && $urandom_range(3) == 0) begin
            new_req(i);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [24:0] issues [$];
      int done_cnt;
      logic prev_draw;

      reset = 1'b1;
      sv = 4'b0; rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin sx[i] = 0; sy[i] = 0; sm[i] = 0; end
      apply_inputs();
      model_reset();
      @(negedge clock);
      @(negedge clock);
      chk("init_draw", {31'd0, draw}, 0);
      chk("init_count", {29'd0, fifoCount}, 0);
      chk("init_ack", {28'd0, reqAck}, 0);
      reset = 1'b0;

      // single request from requester 2
      sx[2] = 8'd10; sy[2] = 9'd20; sm[2] = 8'd3; sv = 4'b0100; rdy = 1'b1;
      step();
      chk("s1_ack", {28'd0, last_ack_dut}, 32'h4);
      chk("s1_count", {29'd0, fifoCount}, 1);
      sv = 4'b0000;
      step();
      chk("s1_draw", {31'd0, draw}, 1);
      chk("s1_x", {24'd0, drawX}, 10);
      chk("s1_y", {23'd0, drawY}, 20);
      chk("s1_mif", {24'd0, drawMif}, 3);
      step();
      chk("s1_hold", {31'd0, draw}, 1);
      rdy = 1'b0;
      step();
      chk("s1_fall", {31'd0, draw}, 0);
      rdy = 1'b1;
      step();
      chk("s1_done", {31'd0, drawDone}, 1);
      step();
      chk("s1_done_pulse", {31'd0, drawDone}, 0);

      // fairness with a stalled drawer
      do_reset();
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) new_req(i);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("fair_ack", {28'd0, last_ack_dut}, 32'd1 << k);
      end
      chk("fair_count", {29'd0, fifoCount}, 4);
      step();
      chk("fair_noack", {28'd0, last_ack_dut}, 0);

      // full FIFO: pop and requester 1 in the same cycle
      sv = 4'b0010; rdy = 1'b1;
      step();
      chk("full_noack", {28'd0, last_ack_dut}, 0);
      chk("full_count3", {29'd0, fifoCount}, 3);
      step();
      chk("full_ack", {28'd0, last_ack_dut}, 32'h2);
      chk("full_count4", {29'd0, fifoCount}, 4);
      sv = 4'b0000;

      // ordering
      do_reset();
      sx[0] = 1; sy[0] = 1; sm[0] = 5;
      sx[1] = 2; sy[1] = 2; sm[1] = 6;
      sx[2] = 3; sy[2] = 3; sm[2] = 7;
      sv = 4'b0111;
      done_cnt = 0; prev_draw = 1'b0;
      for (int n = 0; n < 25; n++) begin
         rdy = !m_draw;
         step();
         if (last_grant >= 0) sv[last_grant] = 1'b0;
         if (draw === 1'b1 && prev_draw === 1'b0) begin
            chk("ord_done_before_issue", done_cnt, issues.size());
            issues.push_back({drawX, drawY, drawMif});
         end
         if (drawDone === 1'b1) done_cnt++;
         prev_draw = draw;
      end
      chk("ord_n", issues.size(), 3);
      chk("ord_0", {7'd0, issues[0]}, {7'd0, 8'd1, 9'd1, 8'd5});
      chk("ord_1", {7'd0, issues[1]}, {7'd0, 8'd2, 9'd2, 8'd6});
      chk("ord_2", {7'd0, issues[2]}, {7'd0, 8'd3, 9'd3, 8'd7});

      // reset while BUSY with two commands queued
      do_reset();
      sv = 4'b0111; rdy = 1'b1;
      step();
      sv[0] = 1'b0;
      step();
      sv[1] = 1'b0; rdy = 1'b0;
      step();
      sv[2] = 1'b0;
      chk("mid_count", {29'd0, fifoCount}, 2);
      chk("mid_busy_draw", {31'd0, draw}, 0);
      do_reset();
      rdy = 1'b1;
      for (int n = 0; n < 5; n++) begin
         step();
         chk("mid_after_draw", {31'd0, draw}, 0);
      end

      // stuck drawer
      do_reset();
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) new_req(i);
      for (int n = 0; n < 12; n++) begin
         step();
         rand_req_update();
      end
      chk("stuck_count", {29'd0, fifoCount}, 4);
      chk("stuck_draw", {31'd0, draw}, 0);

      // random traffic with occasional mid-operation resets
      do_reset();
      sv = 4'b0000;
      for (int n = 0; n < 800; n++) begin
         rdy = ($urandom_range(9) < 7);
         step();
         rand_req_update();
         if ($urandom_range(99) == 0) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
